// File: rtl/noc_pkg.sv
// Shared NoC definitions: node addresses, packet type codes and the 64-bit packet layout
// used by every block that talks to the memory controller's ofmap input.
package noc_pkg;

    localparam logic [3:0] ADDR_PE1 = 4'b0001;
    localparam logic [3:0] ADDR_PE2 = 4'b0010;
    localparam logic [3:0] ADDR_PE3 = 4'b0011;
    localparam logic [3:0] ADDR_PE4 = 4'b0100;
    localparam logic [3:0] ADDR_PE5 = 4'b0101;
    localparam logic [3:0] ADDR_MEM = 4'b0000;

    localparam logic [1:0] TYPE_INPUT  = 2'b00;
    localparam logic [1:0] TYPE_KERNEL = 2'b01;
    localparam logic [1:0] TYPE_OUTPUT = 2'b11;

    // Row/col payloads never reach 31, so all-ones cannot collide with a spike
    localparam logic [9:0] DONE_CODE = 10'h3FF;

    typedef struct packed {
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [1:0]  ptype;
        logic [43:0] pad;
        logic [9:0]  payload;
    } noc_pkt_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } pk_state_t;

    function automatic noc_pkt_t make_out_pkt(input logic [3:0] dst,
                                              input logic [3:0] src,
                                              input logic [9:0] payload);
        noc_pkt_t p;
        p.dst     = dst;
        p.src     = src;
        p.ptype   = TYPE_OUTPUT;
        p.pad     = '0;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Packet FIFO with two ordered write ports (wr0 lands ahead of wr1) and one read port.
// The head entry is presented directly from storage, so read data is registered.
module pkt_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_wr0_en,
    input  logic [WIDTH-1:0] i_wr0_data,
    input  logic             i_wr1_en,
    input  logic [WIDTH-1:0] i_wr1_data,
    input  logic             i_rd_en,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic             w_do0;
    logic             w_do1;
    logic [PW-1:0]    w_wp1;

    // A same-cycle pop counts as free space for the pushes of that cycle
    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_free = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_do0  = i_wr0_en && (w_free != '0);
    assign w_do1  = i_wr1_en && (w_free > CW'(w_do0));
    assign w_wp1  = r_wr_ptr + PW'(w_do0);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do0) begin
                r_mem[r_wr_ptr] <= i_wr0_data;
            end
            if (w_do1) begin
                r_mem[w_wp1] <= i_wr1_data;
            end
            r_wr_ptr <= r_wr_ptr + PW'(w_do0) + PW'(w_do1);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_do0) + CW'(w_do1) - CW'(w_pop);
        end
    end

    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/ofmap_spike_packetizer.sv
// Integrate-and-fire output stage: accumulates partial sums into per-neuron membrane
// potentials and queues one NoC packet per spike plus a DONE packet at each row end.
module ofmap_spike_packetizer
    import noc_pkg::*;
#(
    parameter int                OFMAP_ROWS = 21,
    parameter int                OFMAP_COLS = 21,
    parameter int                PSUM_W     = 12,
    parameter int                VMEM_W     = 16,
    parameter logic [VMEM_W-1:0] THRESHOLD  = VMEM_W'(64),
    parameter logic [3:0]        SRC_ADDR   = 4'b1100,
    parameter logic [3:0]        DST_ADDR   = ADDR_MEM,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum_data,
    input  logic [4:0]        psum_row,
    input  logic [4:0]        psum_col,
    input  logic              psum_last,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [63:0]       pkt_data,
    output logic              busy
);

    localparam int            NEURONS   = OFMAP_ROWS * OFMAP_COLS;
    localparam int            AW        = $clog2(NEURONS);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NEURONS - 1);

    function automatic logic [VMEM_W-1:0] sat_add(input logic [VMEM_W-1:0] a,
                                                  input logic [PSUM_W-1:0] b);
        logic [VMEM_W:0] s;
        s = {1'b0, a} + (VMEM_W + 1)'(b);
        return s[VMEM_W] ? '1 : s[VMEM_W-1:0];
    endfunction

    pk_state_t         r_state;
    pk_state_t         w_state_nxt;
    logic [AW-1:0]     r_clr_addr;
    logic [AW-1:0]     w_clr_addr_nxt;
    logic [VMEM_W-1:0] r_vmem [NEURONS];

    logic              w_busy;
    logic              w_psum_ready;
    logic              w_accept;
    logic              w_in_range;
    logic [31:0]       w_idx;
    logic [AW-1:0]     w_addr;
    logic [VMEM_W-1:0] w_vsum;
    logic              w_fire;
    logic              w_push_spike;
    logic              w_push_done;
    noc_pkt_t          w_spike_pkt;
    noc_pkt_t          w_done_pkt;
    logic [CW-1:0]     w_fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_busy         = 1'b0;
        w_psum_ready   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt    = ST_RUN;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            ST_RUN: begin
                // Two free slots guarantee room for a spike and a DONE in one cycle
                w_psum_ready = (w_fifo_count <= CW'(FIFO_DEPTH - 2));
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign w_accept   = psum_valid && w_psum_ready;
    assign w_idx      = 32'(psum_row) * 32'(OFMAP_COLS) + 32'(psum_col);
    assign w_in_range = (32'(psum_row) < 32'(OFMAP_ROWS)) && (32'(psum_col) < 32'(OFMAP_COLS))
                        && (w_idx < 32'(NEURONS));
    assign w_addr     = w_idx[AW-1:0];

    // Combinational read sees the write from the previous cycle, so no forwarding is needed
    assign w_vsum = sat_add(r_vmem[w_addr], psum_data);
    assign w_fire = (w_vsum >= THRESHOLD);

    assign w_push_spike = w_accept && w_in_range && w_fire;
    assign w_push_done  = w_accept && w_in_range && psum_last;

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_vmem[r_clr_addr] <= '0;
        end else if (w_accept && w_in_range) begin
            r_vmem[w_addr] <= w_fire ? '0 : w_vsum;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            assert (w_in_range);
        end
    end

    assign w_spike_pkt = make_out_pkt(DST_ADDR, SRC_ADDR, {psum_row, psum_col});
    assign w_done_pkt  = make_out_pkt(DST_ADDR, SRC_ADDR, DONE_CODE);

    pkt_fifo #(
        .WIDTH ($bits(noc_pkt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pkt_fifo (
        .clk        (clk),
        .i_rst      (reset),
        .i_wr0_en   (w_push_spike),
        .i_wr0_data (w_spike_pkt),
        .i_wr1_en   (w_push_done),
        .i_wr1_data (w_done_pkt),
        .i_rd_en    (pkt_ready),
        .o_rd_valid (pkt_valid),
        .o_rd_data  (pkt_data),
        .o_count    (w_fifo_count)
    );

    assign psum_ready = w_psum_ready;
    assign busy       = w_busy;

endmodule

// File: tb/tb_ofmap_spike_packetizer.sv
// Directed bench for ofmap_spike_packetizer: one DUT at threshold 64 and one at 16'hFFFF.
module tb_ofmap_spike_packetizer;

    localparam logic [63:0] HDR  = 64'h0CC0_0000_0000_0000;
    localparam logic [63:0] DONE = HDR | 64'h3FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        psum_valid, psum_ready, psum_last;
    logic [11:0] psum_data;
    logic [4:0]  psum_row, psum_col;
    logic        pkt_valid, pkt_ready, busy;
    logic [63:0] pkt_data;

    logic        s_valid, s_ready, s_pkt_valid, s_pkt_ready, s_busy;
    logic [11:0] s_data;
    logic [4:0]  s_row, s_col;
    logic        s_last;
    logic [63:0] s_pkt_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] held;

    always #5 clk = ~clk;

    ofmap_spike_packetizer u_dut (
        .clk(clk), .reset(reset),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .psum_row(psum_row), .psum_col(psum_col), .psum_last(psum_last),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .busy(busy)
    );

    ofmap_spike_packetizer #(.THRESHOLD(16'hFFFF)) u_sat (
        .clk(clk), .reset(reset),
        .psum_valid(s_valid), .psum_ready(s_ready), .psum_data(s_data),
        .psum_row(s_row), .psum_col(s_col), .psum_last(s_last),
        .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready), .pkt_data(s_pkt_data), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] r, input logic [4:0] c, input logic [11:0] d,
                        input logic l);
        int k;
        k = 0;
        psum_row   = r;
        psum_col   = c;
        psum_data  = d;
        psum_last  = l;
        psum_valid = 1'b1;
        while (!psum_ready && k < 50) begin
            tick();
            k++;
        end
        chk("send_ready", 64'(psum_ready), 64'd1);
        tick();
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] exp);
        int k;
        k = 0;
        while (!pkt_valid && k < 50) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 64'(pkt_valid), 64'd1);
        chk(tag, pkt_data, exp);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; psum_valid = 1'b0; psum_last = 1'b0; psum_data = '0;
        psum_row = '0; psum_col = '0; pkt_ready = 1'b0;
        s_valid = 1'b0; s_data = 12'd4095; s_row = 5'd5; s_col = 5'd5; s_last = 1'b0;
        s_pkt_ready = 1'b0;
        repeat (3) tick();

        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_psum_ready", 64'(psum_ready), 64'd0);
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_pkt_data", pkt_data, 64'd0);

        // Clear sweep: 441 cycles busy
        reset = 1'b0;
        for (int i = 1; i <= 441; i++) begin
            tick();
            if (i == 440) begin
                chk("clr_busy_440", 64'(busy), 64'd1);
                chk("clr_ready_440", 64'(psum_ready), 64'd0);
            end
        end
        chk("clr_busy_done", 64'(busy), 64'd0);
        chk("clr_ready_done", 64'(psum_ready), 64'd1);
        chk("clr_no_pkt", 64'(pkt_valid), 64'd0);
        chk("clr_sat_ready", 64'(s_ready), 64'd1);

        // Fire at (3,7): 40 then 30
        send(5'd3, 5'd7, 12'd40, 1'b0);
        chk("fire_sub_none", 64'(pkt_valid), 64'd0);
        send(5'd3, 5'd7, 12'd30, 1'b0);
        chk("fire_latency", 64'(pkt_valid), 64'd1);
        pop_expect("fire_pkt", HDR | 64'h067);
        chk("fire_empty", 64'(pkt_valid), 64'd0);

        // Sub-threshold with last -> DONE only
        send(5'd0, 5'd0, 12'd10, 1'b1);
        pop_expect("last_done", DONE);
        chk("last_single", 64'(pkt_valid), 64'd0);

        // (3,7) restarted from zero after firing
        send(5'd3, 5'd7, 12'd63, 1'b0);
        chk("zero_63_none", 64'(pkt_valid), 64'd0);
        send(5'd3, 5'd7, 12'd1, 1'b0);
        pop_expect("zero_refire", HDR | 64'h067);

        // Spike plus DONE in one cycle
        send(5'd20, 5'd20, 12'd100, 1'b1);
        pop_expect("both_spike", HDR | 64'h294);
        pop_expect("both_done", DONE);
        chk("both_empty", 64'(pkt_valid), 64'd0);

        // Back-to-back accepts to one neuron accumulate
        send(5'd2, 5'd2, 12'd50, 1'b0);
        send(5'd2, 5'd2, 12'd50, 1'b0);
        pop_expect("b2b_fire", HDR | 64'h042);

        // Backpressure
        send(5'd1, 5'd1, 12'd100, 1'b0);
        send(5'd1, 5'd2, 12'd100, 1'b0);
        send(5'd1, 5'd3, 12'd100, 1'b0);
        chk("bp_ready_low", 64'(psum_ready), 64'd0);
        held = pkt_data;
        psum_row = 5'd1; psum_col = 5'd4; psum_data = 12'd100; psum_valid = 1'b1;
        repeat (3) tick();
        chk("bp_still_low", 64'(psum_ready), 64'd0);
        chk("bp_head_stable", pkt_data, held);
        psum_valid = 1'b0;
        pop_expect("bp_pkt0", HDR | 64'h021);
        pop_expect("bp_pkt1", HDR | 64'h022);
        pop_expect("bp_pkt2", HDR | 64'h023);
        chk("bp_drained", 64'(pkt_valid), 64'd0);
        send(5'd1, 5'd4, 12'd100, 1'b1);
        pop_expect("bp_pkt3", HDR | 64'h024);
        pop_expect("bp_done", DONE);

        // Saturation on the FFFF-threshold instance
        s_valid = 1'b1;
        repeat (16) tick();
        chk("sat_no_fire", 64'(s_pkt_valid), 64'd0);
        tick();
        chk("sat_fire", 64'(s_pkt_valid), 64'd1);
        chk("sat_pkt", s_pkt_data, HDR | 64'h0A5);
        tick();
        s_valid = 1'b0;
        s_pkt_ready = 1'b1;
        tick();
        s_pkt_ready = 1'b0;
        chk("sat_once", 64'(s_pkt_valid), 64'd0);

        // Reset mid-burst empties the FIFO
        send(5'd4, 5'd4, 12'd100, 1'b0);
        send(5'd4, 5'd5, 12'd100, 1'b0);
        chk("mid_queued", 64'(pkt_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_ready", 64'(psum_ready), 64'd0);
        chk("mid_pkt_data", pkt_data, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 600 && busy; i++) tick();
        chk("mid_reclear", 64'(busy), 64'd0);
        chk("mid_ready_back", 64'(psum_ready), 64'd1);
        chk("mid_still_empty", 64'(pkt_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
